// File: rtl/clock_pkg.sv
// Shared types and reset constants for the clock mode controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } set_state_t;

    localparam set_state_t RST_STATE = RUN;
    localparam logic       RST_OUT   = 1'b0;
    localparam logic       RST_LVL   = 1'b0;

    function automatic logic is_set(input set_state_t s);
        return (s == SET_HR) || (s == SET_MIN);
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Advance-button edge detect plus hold/auto-repeat timer; pulse is combinational in the sampling cycle.
// No backpressure: clr drops any pulse this cycle and restarts the hold timer.
module btn_repeat #(
    parameter int HOLD_CYC = 50_000_000,
    parameter int RPT_CYC  = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(HOLD_CYC + 1);
    localparam logic [CW-1:0] HOLD_V  = CW'(HOLD_CYC);
    localparam logic [CW-1:0] RPT_V   = CW'(RPT_CYC);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          r_btn_q;
    logic          r_first;
    logic          r_rpt;
    logic [CW-1:0] r_cnt;
    logic          w_rise;
    logic          w_hit;

    // r_first suppresses a false edge from a button already held at reset release
    assign w_rise = btn & ~r_btn_q & ~r_first;
    assign w_hit  = btn & r_btn_q & ~r_first & (r_cnt == (r_rpt ? RPT_V : HOLD_V));
    assign pulse  = ~clr & (w_rise | w_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_q <= 1'b0;
            r_first <= 1'b1;
            r_rpt   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_first <= 1'b0;
            r_btn_q <= btn;
            if (r_first || !btn || clr) begin
                r_cnt <= '0;
                r_rpt <= 1'b0;
            end else if (w_rise || w_hit) begin
                r_cnt <= CNT_ONE;
                r_rpt <= w_hit;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set-hour/set-minute sequencer: gates the 1 Hz enable, routes advance pulses, drives blink.
// All outputs registered, 1-cycle latency; no backpressure.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int HOLD_CYC = 50_000_000,
    parameter int RPT_CYC  = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_adv,
    output logic       enb,
    output logic       adv_hr,
    output logic       adv_min,
    output logic       sec_clr,
    output logic       blank_hr,
    output logic       blank_min,
    output set_state_t mode
);
    set_state_t r_state;
    set_state_t w_next;
    logic       r_mode_q;
    logic       r_first;
    logic       r_blink;
    logic       r_enb, r_adv_hr, r_adv_min, r_sec_clr, r_blank_hr, r_blank_min;

    logic w_mode_edge;
    logic w_state_chg;
    logic w_pulse;
    logic w_blink_nxt;
    logic w_enb_nxt, w_adv_hr_nxt, w_adv_min_nxt, w_sec_clr_nxt;
    logic w_blank_hr_nxt, w_blank_min_nxt;

    assign w_mode_edge = btn_mode & ~r_mode_q & ~r_first;
    assign w_state_chg = (w_next != r_state);

    btn_repeat #(
        .HOLD_CYC(HOLD_CYC),
        .RPT_CYC (RPT_CYC)
    ) u_adv (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_state_chg),
        .btn  (btn_adv),
        .pulse(w_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RST_STATE;
            r_mode_q <= RST_LVL;
            r_first  <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_mode_q <= btn_mode;
            r_first  <= 1'b0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN:     if (w_mode_edge) w_next = SET_HR;
            SET_HR:  if (w_mode_edge) w_next = SET_MIN;
            SET_MIN: if (w_mode_edge) w_next = RUN;
            default: w_next = RUN;
        endcase
    end

    // A state change wins over a same-cycle tick or advance pulse
    always_comb begin
        w_enb_nxt       = (r_state == RUN) & tick_1hz & ~w_state_chg;
        w_adv_hr_nxt    = (r_state == SET_HR) & w_pulse;
        w_adv_min_nxt   = (r_state == SET_MIN) & w_pulse;
        w_sec_clr_nxt   = (r_state == SET_MIN) & (w_next == RUN);
        w_blink_nxt     = (w_state_chg || !is_set(w_next)) ? 1'b0 : (r_blink ^ tick_1hz);
        w_blank_hr_nxt  = (w_next == SET_HR) & w_blink_nxt;
        w_blank_min_nxt = (w_next == SET_MIN) & w_blink_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink     <= RST_OUT;
            r_enb       <= RST_OUT;
            r_adv_hr    <= RST_OUT;
            r_adv_min   <= RST_OUT;
            r_sec_clr   <= RST_OUT;
            r_blank_hr  <= RST_OUT;
            r_blank_min <= RST_OUT;
        end else begin
            r_blink     <= w_blink_nxt;
            r_enb       <= w_enb_nxt;
            r_adv_hr    <= w_adv_hr_nxt;
            r_adv_min   <= w_adv_min_nxt;
            r_sec_clr   <= w_sec_clr_nxt;
            r_blank_hr  <= w_blank_hr_nxt;
            r_blank_min <= w_blank_min_nxt;
        end
    end

    assign enb       = r_enb;
    assign adv_hr    = r_adv_hr;
    assign adv_min   = r_adv_min;
    assign sec_clr   = r_sec_clr;
    assign blank_hr  = r_blank_hr;
    assign blank_min = r_blank_min;
    assign mode      = r_state;

endmodule
